// File: rtl/sim_pkg.sv
// Shared types and address-map constants for the simulation control window.
package sim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_STREAM,
        ST_DONE
    } sim_state_t;

    localparam logic [31:0] ADDR_HALT_DEFAULT = 32'h2000_0000;

    // Register offsets from the halt register, counted in XLEN-wide words.
    localparam int OFS_SIG_BEGIN = 1;
    localparam int OFS_SIG_END   = 2;

    localparam logic [31:0] HALT_CMD = 32'd1;

    function automatic int word_bytes(input int xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/sim_mmio_regs.sv
// Window decode, signature bound registers, halt-command detect and load readback.
// Readback of the window is enabled by defining SIM_READBACK_EN.
module sim_mmio_regs
    import sim_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] ADDR_HALT = ADDR_HALT_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            store,
    input  logic            load,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    input  logic            idle,
    input  logic            halt,
    output logic            mmio_hit,
    output logic            halt_cmd,
    output logic [XLEN-1:0] sig_begin,
    output logic [XLEN-1:0] sig_end,
    output logic [XLEN-1:0] mmio_rdata
);

    localparam int              BYTES   = word_bytes(XLEN);
    localparam int              LSB     = $clog2(BYTES);
    localparam logic [XLEN-1:0] A_HALT  = XLEN'(ADDR_HALT);
    localparam logic [XLEN-1:0] A_BEGIN = A_HALT + XLEN'(OFS_SIG_BEGIN * BYTES);
    localparam logic [XLEN-1:0] A_END   = A_HALT + XLEN'(OFS_SIG_END * BYTES);

    logic            hit_halt;
    logic            hit_begin;
    logic            hit_end;
    logic [XLEN-1:0] aligned_data;
    logic [XLEN-1:0] sig_begin_reg;
    logic [XLEN-1:0] sig_end_reg;

    assign hit_halt  = (address == A_HALT);
    assign hit_begin = (address == A_BEGIN);
    assign hit_end   = (address == A_END);
    assign mmio_hit  = hit_halt | hit_begin | hit_end;

    // Bounds are word addresses: the byte-offset bits are forced to zero.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_align
            if (gi < LSB) begin : g_clr
                assign aligned_data[gi] = 1'b0;
            end else begin : g_keep
                assign aligned_data[gi] = store_data[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            sig_begin_reg <= '0;
            sig_end_reg   <= '0;
        end else if (store && idle) begin
            if (hit_begin) begin
                sig_begin_reg <= aligned_data;
            end
            if (hit_end) begin
                sig_end_reg <= aligned_data;
            end
        end
    end

    assign halt_cmd  = store && idle && hit_halt && (store_data[31:0] == HALT_CMD);
    assign sig_begin = sig_begin_reg;
    assign sig_end   = sig_end_reg;

`ifdef SIM_READBACK_EN
    always_comb begin
        mmio_rdata = '0;
        if (load) begin
            if (hit_halt) begin
                mmio_rdata = {{(XLEN-1){1'b0}}, halt};
            end else if (hit_begin) begin
                mmio_rdata = sig_begin_reg;
            end else if (hit_end) begin
                mmio_rdata = sig_end_reg;
            end
        end
    end
`else
    logic unused_readback;
    assign unused_readback = load ^ halt;
    assign mmio_rdata      = '0;
`endif

endmodule

// File: rtl/sim_halt_responder.sv
// Simulation control responder: on halt, reads the signature region from RAM and
// streams it on a valid/ready port, then raises done. Optional: SIM_READBACK_EN.
module sim_halt_responder
    import sim_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] ADDR_HALT = ADDR_HALT_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            store,
    input  logic            load,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic            mmio_hit,
    output logic [XLEN-1:0] mmio_rdata,
    output logic            mem_re,
    output logic [XLEN-2:0] mem_raddr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            dump_valid,
    output logic [XLEN-1:0] dump_data,
    input  logic            dump_ready,
    output logic            halt,
    output logic            done
);

    localparam logic [XLEN-1:0] STEP = XLEN'(word_bytes(XLEN));

    sim_state_t      state_reg;
    logic [XLEN-1:0] ptr_reg;
    logic [XLEN-1:0] ptr_next;
    logic [XLEN-1:0] dump_data_reg;
    logic [XLEN-2:0] mem_raddr_reg;
    logic            mem_re_reg;
    logic            dump_valid_reg;
    logic            halt_reg;
    logic            done_reg;
    logic            idle;
    logic            halt_cmd;
    logic [XLEN-1:0] sig_begin;
    logic [XLEN-1:0] sig_end;

    assign idle     = (state_reg == ST_IDLE);
    assign ptr_next = ptr_reg + STEP;

    sim_mmio_regs #(
        .XLEN      (XLEN),
        .ADDR_HALT (ADDR_HALT)
    ) u_regs (
        .clock      (clock),
        .reset      (reset),
        .store      (store),
        .load       (load),
        .address    (address),
        .store_data (store_data),
        .idle       (idle),
        .halt       (halt_reg),
        .mmio_hit   (mmio_hit),
        .halt_cmd   (halt_cmd),
        .sig_begin  (sig_begin),
        .sig_end    (sig_end),
        .mmio_rdata (mmio_rdata)
    );

    // The read request is registered on entry to READ, so READ itself only has to
    // decide between WAIT (a read is in flight) and DONE (pointer reached the end).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            dump_data_reg  <= '0;
            mem_raddr_reg  <= '0;
            mem_re_reg     <= 1'b0;
            dump_valid_reg <= 1'b0;
            halt_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (halt_cmd) begin
                        halt_reg      <= 1'b1;
                        ptr_reg       <= sig_begin;
                        mem_re_reg    <= (sig_begin < sig_end);
                        mem_raddr_reg <= sig_begin[XLEN-1:1];
                        state_reg     <= ST_READ;
                    end
                end
                ST_READ: begin
                    mem_re_reg <= 1'b0;
                    if (mem_re_reg) begin
                        state_reg <= ST_WAIT;
                    end else begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    dump_data_reg  <= mem_rdata;
                    dump_valid_reg <= 1'b1;
                    state_reg      <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (dump_ready) begin
                        dump_valid_reg <= 1'b0;
                        ptr_reg        <= ptr_next;
                        mem_re_reg     <= (ptr_next < sig_end);
                        mem_raddr_reg  <= ptr_next[XLEN-1:1];
                        state_reg      <= ST_READ;
                    end
                end
                ST_DONE: begin
                    done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_re     = mem_re_reg;
    assign mem_raddr  = mem_raddr_reg;
    assign dump_valid = dump_valid_reg;
    assign dump_data  = dump_data_reg;
    assign halt       = halt_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_sim_halt_responder.sv
// Bench for sim_halt_responder: RAM model plus expected signature list built from bounds.
module tb_sim_halt_responder;

    localparam logic [31:0] A_HALT  = 32'h2000_0000;
    localparam logic [31:0] A_BEGIN = 32'h2000_0004;
    localparam logic [31:0] A_END   = 32'h2000_0008;

    logic        clock = 1'b0;
    logic        reset;
    logic        store;
    logic        load;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        mmio_hit;
    logic [31:0] mmio_rdata;
    logic        mem_re;
    logic [30:0] mem_raddr;
    logic [31:0] mem_rdata = 32'h0;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic        dump_ready;
    logic        halt;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram [logic [31:0]];

    sim_halt_responder dut (
        .clock      (clock),
        .reset      (reset),
        .store      (store),
        .load       (load),
        .address    (address),
        .store_data (store_data),
        .mmio_hit   (mmio_hit),
        .mmio_rdata (mmio_rdata),
        .mem_re     (mem_re),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_ready (dump_ready),
        .halt       (halt),
        .done       (done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        if (ram.exists(a)) begin
            return ram[a];
        end
        return 32'hBAD0_0000 ^ a;
    endfunction

    // One-cycle-latency RAM read port.
    always @(posedge clock) begin
        if (mem_re) begin
            mem_rdata <= ram_read({mem_raddr, 1'b0});
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        store      = 1'b0;
        load       = 1'b0;
        address    = 32'h0;
        store_data = 32'h0;
        dump_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Called at a negedge; the store is captured on the following posedge.
    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
        store      = 1'b1;
        address    = a;
        store_data = d;
        @(negedge clock);
        store      = 1'b0;
        address    = 32'h0;
        store_data = 32'h0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (halt !== 1'b0) begin n_errors++; $display("FAIL reset_halt: got %b expected 0", halt); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (dump_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", dump_valid); end
        n_checks++;
        if (dump_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", dump_data); end
        n_checks++;
        if (mem_re !== 1'b0 || mem_raddr !== 31'h0) begin
            n_errors++; $display("FAIL reset_mem: got re=%b raddr=%h expected 0/0", mem_re, mem_raddr);
        end
        $display("reset: outputs sampled");
    endtask

    task automatic test_ignored_halt();
        do_reset();
        cpu_store(A_HALT, 32'd2);
        n_checks++;
        if (halt !== 1'b0) begin n_errors++; $display("FAIL halt_value2: got %b expected 0", halt); end
        @(negedge clock);
        n_checks++;
        if (halt !== 1'b0 || mem_re !== 1'b0) begin
            n_errors++; $display("FAIL halt_value2_late: got halt=%b re=%b expected 0/0", halt, mem_re);
        end
        $display("ignored halt: store 2 to halt register");
    endtask

    // mode 0: ready always high, 1: ready low 5 cycles on word 2, 2: random ready
    task automatic test_dump(input string name, input logic [31:0] b, input logic [31:0] e,
                             input int mode, input bit fixed_words, input bit mid_store);
        logic [31:0] exp_words [$];
        logic [30:0] exp_raddr [$];
        logic [30:0] got_raddr [$];
        logic [31:0] ab;
        logic [31:0] ae;
        logic [31:0] a32;
        logic [31:0] w;
        logic [31:0] prev_data;
        bit          prev_stall;
        int          k;
        int          hs;
        int          idx;
        int          stall_left;
        int          last_hs_k;
        int          first_re_k;
        int          first_valid_k;

        do_reset();
        ab  = b & ~32'd3;
        ae  = e & ~32'd3;
        idx = 0;
        for (longint a = longint'(ab); a < longint'(ae); a += 4) begin
            a32 = a[31:0];
            w   = fixed_words ? 32'(10 + idx) : $urandom;
            ram[a32] = w;
            exp_words.push_back(w);
            exp_raddr.push_back(a32[31:1]);
            idx++;
        end

        cpu_store(A_BEGIN, b);
        cpu_store(A_END, e);
        cpu_store(A_HALT, 32'd1);
        n_checks++;
        if (halt !== 1'b1) begin n_errors++; $display("FAIL %s halt_rise: got %b expected 1", name, halt); end

        k = 1; hs = 0; prev_stall = 0; prev_data = 32'h0;
        stall_left = (mode == 1) ? 5 : 0;
        last_hs_k = 0; first_re_k = 0; first_valid_k = 0;
        while (done !== 1'b1 && k < 400) begin
            if (mem_re === 1'b1) begin
                got_raddr.push_back(mem_raddr);
                if (first_re_k == 0) first_re_k = k;
            end
            if (dump_valid === 1'b1 && first_valid_k == 0) first_valid_k = k;
            if (prev_stall) begin
                n_checks++;
                if (dump_valid !== 1'b1 || dump_data !== prev_data) begin
                    n_errors++;
                    $display("FAIL %s hold: got valid=%b data=%h expected 1/%h", name, dump_valid, dump_data, prev_data);
                end
            end
            if (mem_re === 1'b1 && dump_valid === 1'b1) begin
                n_checks++; n_errors++;
                $display("FAIL %s read_while_valid: got mem_re=1 expected 0 at cycle %0d", name, k);
            end
            if (mode == 1 && dump_valid === 1'b1 && hs == 1 && stall_left > 0) begin
                dump_ready = 1'b0;
                stall_left--;
            end else if (mode == 2) begin
                dump_ready = 1'($urandom_range(0, 1));
            end else begin
                dump_ready = 1'b1;
            end
            if (dump_valid === 1'b1 && dump_ready) begin
                n_checks++;
                if (hs >= exp_words.size()) begin
                    n_errors++;
                    $display("FAIL %s extra_word: got word %0d data=%h expected only %0d words", name, hs, dump_data, exp_words.size());
                end else if (dump_data !== exp_words[hs]) begin
                    n_errors++;
                    $display("FAIL %s word%0d: got %h expected %h", name, hs, dump_data, exp_words[hs]);
                end
                $display("%s: word %0d data=%h cycle %0d", name, hs, dump_data, k);
                if (mode == 0 && hs > 0) begin
                    n_checks++;
                    if (k - last_hs_k != 3) begin
                        n_errors++; $display("FAIL %s spacing: got %0d expected 3", name, k - last_hs_k);
                    end
                end
                last_hs_k = k;
                hs++;
            end
            prev_stall = (dump_valid === 1'b1) && !dump_ready;
            prev_data  = dump_data;
            if (mid_store && k == 2) begin
                store = 1'b1; address = A_END; store_data = 32'h0000_0400;
                #1;
                n_checks++;
                if (mmio_hit !== 1'b1) begin n_errors++; $display("FAIL %s hit_after_halt: got %b expected 1", name, mmio_hit); end
            end else if (mid_store && k == 3) begin
                store = 1'b0; address = 32'h0; store_data = 32'h0;
            end
            @(negedge clock);
            k++;
        end
        dump_ready = 1'b0;

        n_checks++;
        if (done !== 1'b1) begin n_errors++; $display("FAIL %s done_timeout: got %b expected 1", name, done); end
        n_checks++;
        if (hs != exp_words.size()) begin
            n_errors++; $display("FAIL %s word_count: got %0d expected %0d", name, hs, exp_words.size());
        end
        n_checks++;
        if (got_raddr.size() != exp_raddr.size()) begin
            n_errors++; $display("FAIL %s read_count: got %0d expected %0d", name, got_raddr.size(), exp_raddr.size());
        end else begin
            for (int i = 0; i < exp_raddr.size(); i++) begin
                n_checks++;
                if (got_raddr[i] !== exp_raddr[i]) begin
                    n_errors++; $display("FAIL %s raddr%0d: got %h expected %h", name, i, got_raddr[i], exp_raddr[i]);
                end
            end
        end
        if (exp_words.size() == 0) begin
            n_checks++;
            if (k != 2 || first_valid_k != 0) begin
                n_errors++; $display("FAIL %s empty_done: got done cycle %0d valid cycle %0d expected 2/0", name, k, first_valid_k);
            end
        end else if (mode == 0) begin
            n_checks++;
            if (first_re_k != 1 || first_valid_k != 3) begin
                n_errors++; $display("FAIL %s latency: got re %0d valid %0d expected 1/3", name, first_re_k, first_valid_k);
            end
        end
        if (mode == 1) begin
            n_checks++;
            if (stall_left != 0) begin n_errors++; $display("FAIL %s stall_applied: got %0d left expected 0", name, stall_left); end
        end
        $display("%s: dump finished, %0d words", name, hs);
    endtask

    task automatic test_reset_mid_dump();
        int k;
        do_reset();
        for (int i = 0; i < 4; i++) ram[32'h100 + 32'(4 * i)] = 32'(10 + i);
        cpu_store(A_BEGIN, 32'h100);
        cpu_store(A_END, 32'h110);
        cpu_store(A_HALT, 32'd1);
        k = 0;
        while (dump_valid !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (dump_valid !== 1'b1) begin n_errors++; $display("FAIL midreset_reach_stream: got %b expected 1", dump_valid); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({halt, done, dump_valid, mem_re} !== 4'b0 || dump_data !== 32'h0 || mem_raddr !== 31'h0) begin
            n_errors++;
            $display("FAIL midreset_clear: got halt=%b done=%b valid=%b re=%b data=%h raddr=%h expected all 0",
                     halt, done, dump_valid, mem_re, dump_data, mem_raddr);
        end
        cpu_store(A_HALT, 32'd1);
        n_checks++;
        if (halt !== 1'b1 || mem_re !== 1'b0) begin
            n_errors++; $display("FAIL midreset_rehalt: got halt=%b re=%b expected 1/0", halt, mem_re);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b1 || dump_valid !== 1'b0) begin
            n_errors++; $display("FAIL midreset_empty: got done=%b valid=%b expected 1/0", done, dump_valid);
        end
        $display("reset mid-dump: re-halt with cleared bounds");
    endtask

    task automatic test_readback();
        logic [31:0] exp_begin;
        do_reset();
        cpu_store(A_BEGIN, 32'h103);
`ifdef SIM_READBACK_EN
        exp_begin = 32'h100;
`else
        exp_begin = 32'h0;
`endif
        load = 1'b1; address = A_BEGIN;
        #1;
        n_checks++;
        if (mmio_rdata !== exp_begin) begin n_errors++; $display("FAIL readback_begin: got %h expected %h", mmio_rdata, exp_begin); end
        n_checks++;
        if (mmio_hit !== 1'b1) begin n_errors++; $display("FAIL hit_begin: got %b expected 1", mmio_hit); end
        address = A_HALT;
        #1;
        n_checks++;
        if (mmio_rdata !== 32'h0) begin n_errors++; $display("FAIL readback_halt: got %h expected 0", mmio_rdata); end
        address = 32'h2000_000C;
        #1;
        n_checks++;
        if (mmio_hit !== 1'b0 || mmio_rdata !== 32'h0) begin
            n_errors++; $display("FAIL outside_window: got hit=%b data=%h expected 0/0", mmio_hit, mmio_rdata);
        end
        load = 1'b0; address = 32'h0;
        @(negedge clock);
        $display("readback: window loads sampled");
    endtask

    initial begin
        logic [31:0] rb;
        logic [31:0] re;
        test_reset();
        test_ignored_halt();
        test_dump("no_bounds", 32'h0, 32'h0, 0, 0, 0);
        test_dump("basic", 32'h100, 32'h110, 0, 1, 0);
        test_dump("backpressure", 32'h100, 32'h110, 1, 1, 0);
        test_dump("unaligned", 32'h103, 32'h10B, 0, 0, 0);
        test_dump("store_after_halt", 32'h100, 32'h110, 2, 0, 1);
        test_dump("inverted", 32'h300, 32'h200, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            rb = 32'h1000 + 32'($urandom_range(0, 63) * 4);
            re = rb + 32'($urandom_range(0, 6) * 4) + 32'($urandom_range(0, 3));
            test_dump("random", rb, re, 2, 0, 0);
        end
        test_reset_mid_dump();
        test_readback();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sim_halt_responder.md
# sim_halt_responder

Memory-mapped responder on the CPU data port for the simulation control window. It captures signature-region bounds and the halt command written by the CPU. On halt it becomes a reader of the data RAM: it fetches every signature word and streams the words out on a valid/ready port for the bench, then asserts `done`. It sits beside `ram_dp` in `top`, snooping the same `store`/`address`/`store_data` bus, and owns a dedicated RAM read port.

## Interface
- `XLEN`, 32: data and address width; 32 or 64.
- `ADDR_HALT`, 32'h20000000: halt register byte address.
- Derived, not parameters: `ADDR_SIG_BEGIN = ADDR_HALT + XLEN/8`, `ADDR_SIG_END = ADDR_SIG_BEGIN + XLEN/8`.

Ports:
- `clock`, in, 1: sole clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `store`, in, 1: CPU store strobe.
- `load`, in, 1: CPU load strobe.
- `address`, in, XLEN: CPU byte address.
- `store_data`, in, XLEN: CPU store data.
- `mmio_hit`, out, 1: combinational; `address` lies in the 3-register window.
- `mmio_rdata`, out, XLEN: combinational load data for the window.
- `mem_re`, out, 1: RAM read enable.
- `mem_raddr`, out, XLEN-1: RAM halfword address (byte address >> 1).
- `mem_rdata`, in, XLEN: RAM data, valid the cycle after `mem_re`.
- `dump_valid`, out, 1: signature word available.
- `dump_data`, out, XLEN: signature word.
- `dump_ready`, in, 1: bench accepts the word.
- `halt`, out, 1: halt accepted (sticky).
- `done`, out, 1: dump complete (sticky).

## Operation
- Registers `sig_begin` and `sig_end` hold byte addresses, XLEN wide, reset 0.
- Store to `ADDR_SIG_BEGIN` / `ADDR_SIG_END` loads the register from `store_data` with the low log2(XLEN/8) bits cleared. These stores take effect in IDLE only.
- Store to `ADDR_HALT` with `store_data[31:0]==1` in IDLE starts the dump. Any other value is ignored.
- FSM states:
  - IDLE: waits for the halt command.
  - READ: `ptr` initialised to `sig_begin`.
    - If `ptr >= sig_end`, go to DONE.
    - Otherwise assert `mem_re` with `mem_raddr = ptr >> 1` and go to WAIT.
  - WAIT: capture `mem_rdata` into `dump_data`, set `dump_valid`, go to STREAM.
  - STREAM: hold `dump_valid` and `dump_data` stable until `dump_ready`. On the handshake, `ptr += XLEN/8`, drop `dump_valid`, go to READ.
  - DONE: `done=1`. The state is terminal until reset.
- `begin >= end` (including both 0): zero words dumped; `done` rises 2 cycles after the halt store.
- Word count is `(sig_end - sig_begin) / (XLEN/8)`. Unsigned comparison; no wrap past 2^XLEN.
- After `halt`, all stores to the window are ignored. `mmio_hit` still reports decode.
- Loads to the window return 0 unless `SIM_READBACK_EN` is defined.

## Timing
- Reset values: `halt=0`, `done=0`, `dump_valid=0`, `dump_data=0`, `mem_re=0`, `mem_raddr=0`, `sig_begin=0`, `sig_end=0`, state IDLE.
- Halt store at edge N: `halt=1` after N, READ after N.
- First `mem_re` in cycle N+1; first `dump_valid` in cycle N+3.
- With `dump_ready` tied 1, throughput is one word per 3 cycles.
- `dump_ready` asserted while `dump_valid=0` has no effect.
- Reset mid-dump returns to IDLE next edge and clears all outputs and registers.

## Configuration
- `SIM_READBACK_EN` defined: a load to the window returns `sig_begin`, `sig_end`, or `{XLEN-1'b0, halt}` on `mmio_rdata`.
- `SIM_READBACK_EN` undefined: `mmio_rdata` is constant 0 and `load` is unused.

## Structure
- Shared package `sim_pkg`:
  - FSM state enum (IDLE/READ/WAIT/STREAM/DONE).
  - `ADDR_HALT` default.
  - Offset constants for SIG_BEGIN and SIG_END.
- One sub-module, `sim_mmio_regs`: address decode, `sig_begin`/`sig_end`, halt-command detect, readback mux.
- FSM, pointer and stream stage live in the top of the block.

## Test plan
- Halt with no prior bounds: store 1 to 0x20000000 -> `halt` at N+1, `done` at N+2, `dump_valid` never asserted.
- XLEN=32, begin=0x100, end=0x110, RAM words 0xA,0xB,0xC,0xD, `dump_ready=1`:
  - `mem_raddr` = 0x80, 0x82, 0x84, 0x86.
  - Words 0xA..0xD streamed in order.
  - `done` after 4 handshakes.
- Backpressure: same setup with `dump_ready` low for 5 cycles on word 2 -> `dump_data` held at 0xB, no extra `mem_re`, no word lost or duplicated.
- Ignored commands:
  - Store 2 to halt -> `halt` stays 0.
  - Store begin=0x200 after halt -> `sig_begin` unchanged.
  - Unaligned begin 0x103 -> stored as 0x100.
- Reset during STREAM of word 1 -> next cycle all outputs 0. A fresh halt dumps from `sig_begin=0`, `sig_end=0`, so zero words.
- With `SIM_READBACK_EN`: load 0x20000004 after writing 0x100 -> `mmio_rdata=0x100`. Without it -> 0.
